// File: rtl/spi_slave_pkg.sv
// Shared frame constants, command codes and FSM state type for the SPI brightness slave.
package spi_slave_pkg;

  localparam int unsigned MASTER_FRAME_WIDTH   = 24;
  localparam int unsigned CMD_BITS             = 8;
  localparam int unsigned ADDR_BITS            = 8;
  localparam int unsigned PAYLOAD_BITS         = 8;
  localparam int unsigned BRIGHTNESS_WIDTH     = 7;
  localparam int unsigned CLKS_PER_MASTER_SCLK = 4;

  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h02;
  localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCommand,
    StAddress,
    StPayload,
    StDone
  } spi_state_e;

  function automatic logic addr_ok(input logic [ADDR_BITS-1:0] addr, input int unsigned num_ch);
    return 32'(addr) < num_ch;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input; resets to the line's idle level.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 slave exposing NUM_CHANNELS 7-bit brightness registers over 24-bit frames.
// Define SPI_SLAVE_ERR_CNT_EN to add the saturating o_err_cnt abort/void-frame counter.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                                       sysclk,
  input  logic                                       rst_n,
  input  logic                                       cs,
  input  logic                                       sclk,
  input  logic                                       mosi,
  output logic                                       miso,
  output logic [NUM_CHANNELS*BRIGHTNESS_WIDTH-1:0]   o_brightness,
  output logic                                       o_wr_valid,
  output logic [1:0]                                 o_wr_addr
`ifdef SPI_SLAVE_ERR_CNT_EN
  ,
  output logic [7:0]                                 o_err_cnt
`endif
);

  localparam int unsigned ChIdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic cs_s, sclk_s, mosi_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_DEASSERT)) u_sync_cs (
    .clk_i (sysclk), .rst_ni(rst_n), .d_i(cs), .q_o(cs_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i (sysclk), .rst_ni(rst_n), .d_i(sclk), .q_o(sclk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i (sysclk), .rst_ni(rst_n), .d_i(mosi), .q_o(mosi_s)
  );

  spi_state_e                                    state_q, state_d;
  logic                                          sclk_prev_q, cs_prev_q;
  logic [4:0]                                    cnt_q, cnt_d;
  logic [MASTER_FRAME_WIDTH-1:0]                 rx_q, rx_d, frame;
  logic [PAYLOAD_BITS-1:0]                       tx_q, tx_d;
  logic                                          tx_active_q, tx_active_d;
  logic                                          rd_en_q, rd_en_d;
  logic [ChIdxW-1:0]                             rd_idx_q, rd_idx_d;
  logic [NUM_CHANNELS-1:0][BRIGHTNESS_WIDTH-1:0] ch_q, ch_d;
  logic                                          wr_valid_q, wr_valid_d;
  logic [1:0]                                    wr_addr_q, wr_addr_d;
  logic                                          rise, fall, cs_off, cs_fall;
  logic                                          wr_ok, rd_ok, err_inc;

  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign cs_off  = (cs_s == CS_DEASSERT);
  assign cs_fall = (cs_prev_q == CS_DEASSERT) && (cs_s == CS_ASSERT);
  // Frame as it stands including the bit arriving on this rising edge.
  assign frame   = {rx_q[MASTER_FRAME_WIDTH-2:0], mosi_s};
  assign wr_ok   = (frame[23:16] == CMD_WRITE) && addr_ok(frame[15:8], NUM_CHANNELS);
  assign rd_ok   = (frame[23:16] == CMD_READ) && addr_ok(frame[15:8], NUM_CHANNELS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    tx_active_d = tx_active_q;
    rd_en_d     = rd_en_q;
    rd_idx_d    = rd_idx_q;
    ch_d        = ch_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d     = StCommand;
          cnt_d       = '0;
          rx_d        = '0;
          tx_d        = '0;
          tx_active_d = 1'b0;
          rd_en_d     = 1'b0;
        end
      end
      StCommand, StAddress, StPayload: begin
        if (rise) begin
          rx_d  = frame;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            state_d = StAddress;
          end else if (cnt_q == 5'd15) begin
            state_d  = StPayload;
            rd_en_d  = (frame[15:8] == CMD_READ) && addr_ok(frame[7:0], NUM_CHANNELS);
            rd_idx_d = frame[ChIdxW-1:0];
          end else if (cnt_q == 5'd23) begin
            state_d     = StDone;
            tx_active_d = 1'b0;
            if (wr_ok) begin
              ch_d[frame[8+ChIdxW-1:8]] = frame[BRIGHTNESS_WIDTH-1:0];
              wr_valid_d                = 1'b1;
              wr_addr_d                 = frame[9:8];
            end else if (!rd_ok) begin
              err_inc = 1'b1;
            end
          end
        end else if (fall && (state_q == StPayload) && rd_en_q) begin
          // First falling edge of the payload loads the channel; later ones shift.
          tx_d        = tx_active_q ? {tx_q[PAYLOAD_BITS-2:0], 1'b0} : {1'b0, ch_q[rd_idx_q]};
          tx_active_d = 1'b1;
        end
        // A 24th edge coinciding with cs release still commits the frame.
        if (cs_off && !(rise && (cnt_q == 5'd23))) begin
          state_d     = StIdle;
          tx_active_d = 1'b0;
          rd_en_d     = 1'b0;
          err_inc     = 1'b1;
        end
      end
      StDone: begin
        tx_active_d = 1'b0;
        if (cs_off) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= CS_DEASSERT;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      tx_active_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_idx_q    <= '0;
      ch_q        <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      tx_active_q <= tx_active_d;
      rd_en_q     <= rd_en_d;
      rd_idx_q    <= rd_idx_d;
      ch_q        <= ch_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign miso         = tx_active_q & tx_q[PAYLOAD_BITS-1] & ~cs_off;
  assign o_brightness = ch_q;
  assign o_wr_valid   = wr_valid_q;
  assign o_wr_addr    = wr_addr_q;

  logic unused_rx_msb;
  assign unused_rx_msb = rx_q[MASTER_FRAME_WIDTH-1];

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
`endif

endmodule
